inst_fetch_unit: RTL

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ==========================================================================
// Module   : inst_fetch_unit
// Purpose  : Single-outstanding instruction fetch with redirect and faults
// Revision : 1.0 - initial release
// ==========================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_drop;

  logic        w_launch;
  logic        w_capture;
  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_next;

  assign w_pc_inc = r_pc + 32'd4;

  // Every new fetch starts at the updated pc, so the launch address is w_pc_next.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
    end else if (r_state == HOLD && out_ready) begin
      w_pc_next = w_pc_inc;
    end

    w_launch  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: w_launch = 1'b1;
      DATA: begin
        if (mem_rvalid) begin
          if (redirect_valid || r_drop) begin
            w_launch = 1'b1;
          end else begin
            w_capture = 1'b1;
          end
        end
      end
      HOLD:    w_launch = redirect_valid || out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_drop      <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_araddr  <= 32'd0;
      mem_rready  <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= 32'd0;
      out_inst    <= 32'd0;
      out_fault   <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_launch) begin
        r_req_addr <= w_pc_next;
        r_drop     <= 1'b0;
        mem_rready <= 1'b0;
        // A misaligned target never reaches the bus; it is reported as a fault.
        if (w_pc_next[1:0] != 2'b00) begin
          r_state     <= HOLD;
          mem_arvalid <= 1'b0;
          out_valid   <= 1'b1;
          out_fault   <= 1'b1;
          out_inst    <= 32'd0;
          out_pc      <= w_pc_next;
        end else begin
          r_state     <= ADDR;
          mem_arvalid <= 1'b1;
          mem_araddr  <= w_pc_next;
          out_valid   <= 1'b0;
        end
      end else begin
        if (redirect_valid) begin
          r_drop <= 1'b1;
        end
        case (r_state)
          ADDR: begin
            if (mem_arvalid && mem_arready) begin
              r_state     <= DATA;
              mem_arvalid <= 1'b0;
              mem_rready  <= 1'b1;
            end
          end
          DATA: begin
            if (w_capture) begin
              r_state    <= HOLD;
              mem_rready <= 1'b0;
              out_valid  <= 1'b1;
              out_inst   <= mem_rdata;
              out_pc     <= r_req_addr;
              out_fault  <= |mem_rresp;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
